aes_add_round_key: RTL and testbench
====================================

Name: aes_add_round_key

Overview:
- AddRoundKey stage of the AES-128 encryption round datapath, placed directly downstream of the MixColumns stage.
- Consumes MixColumns state_out/done (or the plaintext for round 0, or the ShiftRows output for the final round), XORs it with the current round key, and emits the result with a one-cycle done strobe.
- Generates round keys on the fly: one key-schedule step per accepted block, so no 11-entry key table is stored.

Parameters:
- NR, 10, number of rounds after round 0; legal range 1..10; round keys 0..NR are produced.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- key_load  input  1  latch key_in as round key 0 and restart the schedule.
- key_in  input  128  cipher key; byte 0 at [127:120] (FIPS-197 order).
- enable  input  1  accept state_in this cycle; driven from the upstream stage's done.
- state_in  input  128  state; byte 0 at [127:120], column c = [127-32c -: 32].
- state_out  output  128  state_in XOR round key, registered.
- done  output  1  one-cycle strobe, high the cycle after an accepted enable.
- round_idx  output  4  index of the round key used for the current state_out (0..NR).
- last  output  1  high together with done when round_idx == NR.
- err  output  1  one-cycle strobe on a rejected enable.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state_out=0, done=0, round_idx=0, last=0, err=0.
  - Internal key_valid=0, rnd=0, rcon=8'h01.
  - rst overrides key_load and enable in the same cycle.
  - Reset mid-sequence discards the key; a new key_load is required.
- key_load: round-key register <= key_in, rnd <= 0, rcon <= 01, key_valid <= 1. Takes effect the next cycle.
- Precedence: key_load has priority over enable in the same cycle. That enable is ignored: no done, no err, no key advance.
- Accepted enable (key_valid=1, rnd<=NR, no key_load):
  - state_out <= state_in ^ rk; done <= 1; round_idx <= rnd; last <= (rnd==NR).
  - rk <= next_key(rk, rcon); rnd <= rnd+1; rcon <= xtime(rcon).
  - Latency is exactly 1 cycle. Back-to-back enables are accepted every cycle; the schedule advances once per enable.
- next_key: split rk into w0..w3 (w0 = [127:96]).
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Four S-box instances, computed combinationally within one cycle.
- S-box: GF(2^8) multiplicative inverse modulo x^8+x^4+x^3+x+1 (inverse of 0 is 0), followed by the FIPS-197 affine transform with constant 8'h63.
  - Implemented as a function with arithmetic only, no 256-entry table.
- xtime: left shift by 1, XOR 8'h1b if the MSB was set. The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- Rejected enable (key_valid=0, or rnd>NR, i.e. schedule exhausted):
  - err <= 1 for one cycle, done <= 0.
  - state_out, round_idx and the key state are unchanged.
- enable=0 (and no key_load): done <= 0, err <= 0, last <= 0. state_out and round_idx hold.
- After round NR is consumed, rnd=NR+1. Every further enable raises err until key_load or rst. There is no wrap-around.
- state_in need only be valid in the enable cycle. No internal state buffering beyond state_out.

Test Plan:
1. rst held 2 cycles, then released → all outputs 0. An enable before any key_load → err=1 for one cycle, done=0, state_out=0.
2. key_load with key 2b7e151628aed2a6abf7158809cf4f3c, then enable with state 3243f6a8885a308d313198a2e0370734 → next cycle done=1, round_idx=0, state_out=193de3bea0f4e22b9ac68d2ae9f84808.
3. Continuing from scenario 2, enable with 046681e5e0cb199a48f8d37a2806264c → state_out=a49c7ff2689f352b6b5bea43026a5049, round_idx=1. This checks round key a0fafe1788542cb123a339392a6c7605.
4. key_load, then 11 back-to-back enables with state 0 → state_out walks round keys 0..10. The last is d014f9a8c9ee2589e13f0cc8b6630ca6 with last=1, done high 11 consecutive cycles. A 12th enable → err=1, state_out unchanged.
5. key_load and enable asserted in the same cycle → no done, no err. The following enable uses round key 0.
6. rst asserted between rounds 5 and 6 → outputs cleared. A subsequent enable → err. key_load followed by enable → round_idx=0 and the correct round-key-0 result.

Source files
------------

// File: rtl/aes_add_round_key.sv
// AES-128 AddRoundKey stage: XORs the incoming state with the current round key
// and advances an on-the-fly key schedule by one step per accepted block.
module aes_add_round_key #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
   input  logic         enable,
   input  logic [127:0] state_in,
   output logic [127:0] state_out,
   output logic         done,
   output logic [3:0]   round_idx,
   output logic         last,
   output logic         err
);

   localparam int unsigned RND_W  = 4;
   localparam int unsigned WORD_W = 32;
   localparam logic [RND_W-1:0] NR_IDX = RND_W'(NR);

   if (NR < 1 || NR > 10) begin : g_bad_nr
      $error("aes_add_round_key: NR must be in 1..10");
   end

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 == a^-1 for nonzero a, and maps 0 to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   logic [127:0]      rk;
   logic [RND_W-1:0]  rnd;
   logic [7:0]        rcon;
   logic              key_valid;

   logic [WORD_W-1:0] w0, w1, w2, w3;
   logic [WORD_W-1:0] t, n0, n1, n2, n3;
   logic [127:0]      rk_next;
   logic              accept;

   // One key-expansion step from the current round key.
   assign w0 = rk[127:96];
   assign w1 = rk[95:64];
   assign w2 = rk[63:32];
   assign w3 = rk[31:0];
   assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign rk_next = {n0, n1, n2, n3};

   assign accept = key_valid && (rnd <= NR_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_out <= '0;
         done      <= 1'b0;
         round_idx <= '0;
         last      <= 1'b0;
         err       <= 1'b0;
         rk        <= '0;
         rnd       <= '0;
         rcon      <= 8'h01;
         key_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         last <= 1'b0;
         if (key_load) begin
            rk        <= key_in;
            rnd       <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b1;
         end else if (enable) begin
            if (accept) begin
               state_out <= state_in ^ rk;
               done      <= 1'b1;
               round_idx <= rnd;
               last      <= (rnd == NR_IDX);
               rk        <= rk_next;
               rnd       <= rnd + RND_W'(1);
               rcon      <= xtime(rcon);
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_add_round_key.sv
// Bench for aes_add_round_key: FIPS-197 round-key vectors checked through an
// expected-result queue, plus reject, collision and mid-sequence reset cases.
module tb_aes_add_round_key;

   logic         clk;
   logic         rst;
   logic         key_load;
   logic [127:0] key_in;
   logic         enable;
   logic [127:0] state_in;
   logic [127:0] state_out;
   logic         done;
   logic [3:0]   round_idx;
   logic         last;
   logic         err;

   aes_add_round_key #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_load  (key_load),
      .key_in    (key_in),
      .enable    (enable),
      .state_in  (state_in),
      .state_out (state_out),
      .done      (done),
      .round_idx (round_idx),
      .last      (last),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] state;
      logic [3:0]   idx;
      logic         last;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] rk_tab [0:10];
   logic [127:0] key0;
   int           n_checks;
   int           n_fail;

   // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic tick(input logic kl, input logic en, input logic [127:0] k,
                       input logic [127:0] s);
      key_load = kl;
      enable   = en;
      key_in   = k;
      state_in = s;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick(1'b0, 1'b0, '0, '0);
      tick(1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      tick(1'b0, 1'b0, '0, '0);
      n_checks++;
      if (state_out !== 128'h0) begin
         n_fail++; $display("FAIL reset_state_out: got %h expected 0", state_out);
      end
      n_checks++;
      if ({done, round_idx, last, err} !== 7'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0", {done, round_idx, last, err});
      end
      tick(1'b0, 1'b1, '0, rand128());
      n_checks++;
      if ({err, done} !== 2'b10) begin
         n_fail++; $display("FAIL nokey_err_done: got %b expected 10", {err, done});
      end
      n_checks++;
      if (state_out !== 128'h0) begin
         n_fail++; $display("FAIL nokey_state_out: got %h expected 0", state_out);
      end
      tick(1'b0, 1'b0, '0, '0);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL nokey_err_strobe: got %b expected 0", err);
      end
   endtask

   task automatic test_fips_vector();
      logic [127:0] st [0:1];
      logic [127:0] ex [0:1];
      exp_t e;
      st[0] = 128'h3243f6a8885a308d313198a2e0370734;
      ex[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      st[1] = 128'h046681e5e0cb199a48f8d37a2806264c;
      ex[1] = 128'ha49c7ff2689f352b6b5bea43026a5049;
      tick(1'b1, 1'b0, key0, '0);
      n_checks++;
      if ({done, err} !== 2'b00) begin
         n_fail++; $display("FAIL fips_load_flags: got %b expected 00", {done, err});
      end
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{state: ex[i], idx: 4'(i), last: 1'b0});
         tick(1'b0, 1'b1, '0, st[i]);
         e = sb.pop_front();
         n_checks++;
         if (done !== 1'b1) begin
            n_fail++; $display("FAIL fips_done[%0d]: got %b expected 1", i, done);
         end
         n_checks++;
         if (state_out !== e.state) begin
            n_fail++; $display("FAIL fips_state[%0d]: got %h expected %h", i, state_out, e.state);
         end
         n_checks++;
         if ({round_idx, last} !== {e.idx, e.last}) begin
            n_fail++; $display("FAIL fips_idx[%0d]: got %h/%b expected %h/%b",
                               i, round_idx, last, e.idx, e.last);
         end
      end
      tick(1'b0, 1'b0, '0, rand128());
      n_checks++;
      if ({done, state_out} !== {1'b0, ex[1]}) begin
         n_fail++; $display("FAIL fips_hold: got %b/%h expected 0/%h", done, state_out, ex[1]);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      tick(1'b1, 1'b0, key0, '0);
      for (int i = 0; i <= 10; i++) begin
         sb.push_back('{state: rk_tab[i], idx: 4'(i), last: (i == 10)});
         tick(1'b0, 1'b1, '0, '0);
         e = sb.pop_front();
         n_checks++;
         if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done[%0d]: got %b expected 1", i, done);
         end
         n_checks++;
         if (state_out !== e.state) begin
            n_fail++; $display("FAIL b2b_rk[%0d]: got %h expected %h", i, state_out, e.state);
         end
         n_checks++;
         if ({round_idx, last, err} !== {e.idx, e.last, 1'b0}) begin
            n_fail++; $display("FAIL b2b_idx[%0d]: got %h/%b/%b expected %h/%b/0",
                               i, round_idx, last, err, e.idx, e.last);
         end
      end
      tick(1'b0, 1'b1, '0, rand128());
      n_checks++;
      if ({err, done, last} !== 3'b100) begin
         n_fail++; $display("FAIL exhausted_flags: got %b expected 100", {err, done, last});
      end
      n_checks++;
      if ({state_out, round_idx} !== {rk_tab[10], 4'd10}) begin
         n_fail++; $display("FAIL exhausted_hold: got %h/%h expected %h/a",
                            state_out, round_idx, rk_tab[10]);
      end
      tick(1'b0, 1'b1, '0, rand128());
      n_checks++;
      if ({err, done} !== 2'b10) begin
         n_fail++; $display("FAIL exhausted_again: got %b expected 10", {err, done});
      end
   endtask

   task automatic test_load_enable_collision();
      logic [127:0] s;
      exp_t e;
      tick(1'b1, 1'b1, key0, rand128());
      n_checks++;
      if ({done, err} !== 2'b00) begin
         n_fail++; $display("FAIL collide_flags: got %b expected 00", {done, err});
      end
      for (int i = 0; i < 2; i++) begin
         s = rand128();
         sb.push_back('{state: s ^ rk_tab[i], idx: 4'(i), last: 1'b0});
         tick(1'b0, 1'b1, '0, s);
         e = sb.pop_front();
         n_checks++;
         if ({done, state_out} !== {1'b1, e.state}) begin
            n_fail++; $display("FAIL collide_state[%0d]: got %b/%h expected 1/%h",
                               i, done, state_out, e.state);
         end
         n_checks++;
         if (round_idx !== e.idx) begin
            n_fail++; $display("FAIL collide_idx[%0d]: got %h expected %h", i, round_idx, e.idx);
         end
      end
   endtask

   task automatic test_reset_mid_sequence();
      logic [127:0] s;
      exp_t e;
      tick(1'b1, 1'b0, key0, '0);
      for (int i = 0; i < 6; i++) begin
         s = rand128();
         sb.push_back('{state: s ^ rk_tab[i], idx: 4'(i), last: 1'b0});
         tick(1'b0, 1'b1, '0, s);
         e = sb.pop_front();
         n_checks++;
         if ({done, state_out, round_idx} !== {1'b1, e.state, e.idx}) begin
            n_fail++; $display("FAIL mid_round[%0d]: got %b/%h/%h expected 1/%h/%h",
                               i, done, state_out, round_idx, e.state, e.idx);
         end
      end
      rst = 1'b1;
      tick(1'b1, 1'b1, key0, rand128());
      rst = 1'b0;
      n_checks++;
      if ({state_out, done, round_idx, last, err} !== 135'b0) begin
         n_fail++; $display("FAIL mid_reset_clear: got %h/%b/%h/%b/%b expected all 0",
                            state_out, done, round_idx, last, err);
      end
      tick(1'b0, 1'b1, '0, rand128());
      n_checks++;
      if ({err, done} !== 2'b10) begin
         n_fail++; $display("FAIL mid_reset_nokey: got %b expected 10", {err, done});
      end
      tick(1'b1, 1'b0, key0, '0);
      s = rand128();
      sb.push_back('{state: s ^ rk_tab[0], idx: 4'd0, last: 1'b0});
      tick(1'b0, 1'b1, '0, s);
      e = sb.pop_front();
      n_checks++;
      if ({done, state_out, round_idx} !== {1'b1, e.state, e.idx}) begin
         n_fail++; $display("FAIL mid_reload: got %b/%h/%h expected 1/%h/%h",
                            done, state_out, round_idx, e.state, e.idx);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      key_load = 1'b0;
      enable   = 1'b0;
      key_in   = '0;
      state_in = '0;
      key0      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      test_reset();
      test_fips_vector();
      test_back_to_back();
      test_load_enable_collision();
      test_reset_mid_sequence();

      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
